// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: four-state sequencer that owns an 8-entry register file.
// It accepts one 12-bit instruction per handshake and feeds the external
// combinational ALU. It writes the result back and keeps the flags of the
// last completed instruction.
module alu_seq_ctrl #(
  parameter int NREG = 8,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Ins_valid,
  output logic         Ins_ready,
  input  logic [11:0]  Ins,
  input  logic         Ld_en,
  input  logic [2:0]   Ld_addr,
  input  logic [W-1:0] Ld_data,
  input  logic [2:0]   Dbg_addr,
  output logic [W-1:0] Dbg_data,
  output logic [W-1:0] Alu_Rx,
  output logic [W-1:0] Alu_Ry,
  output logic [2:0]   Alu_Sel,
  input  logic [W-1:0] Alu_R0,
  input  logic [2:0]   Alu_Flags,
  output logic [2:0]   Flags_q,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t       state_q, state_d;
  logic         idle_d;
  logic [2:0]   op_q, rd_q, rx_q, ry_q;
  logic [W-1:0] rf_q [NREG];
  logic [W-1:0] res_q;
  logic [2:0]   flg_q;
  logic         accept;
  logic         ld_ok;

  // Handshake and load qualification. Loads are accepted only while ready,
  // so they can never collide with a writeback.
  assign Ins_ready = idle_d & ~rst;
  assign accept    = Ins_valid & Ins_ready;
  assign ld_ok     = Ld_en & Ins_ready;
  assign Dbg_data  = rf_q[Dbg_addr];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and status outputs
  always_comb begin
    state_d = state_q;
    idle_d  = 1'b0;
    Busy    = 1'b1;
    Done    = 1'b0;
    case (state_q)
      IDLE: begin
        idle_d = 1'b1;
        Busy   = 1'b0;
        if (accept) state_d = READ;
      end
      READ: state_d = EXEC;
      EXEC: state_d = WB;
      WB: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction fields, captured only at the accept edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      rd_q <= '0;
      rx_q <= '0;
      ry_q <= '0;
    end else if (state_q == IDLE && Ins_valid) begin
      op_q <= Ins[11:9];
      rd_q <= Ins[8:6];
      rx_q <= Ins[5:3];
      ry_q <= Ins[2:0];
    end
  end

  // ALU operand/opcode registers; they hold their values outside READ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Alu_Rx  <= '0;
      Alu_Ry  <= '0;
      Alu_Sel <= '0;
    end else if (state_q == READ) begin
      Alu_Rx  <= rf_q[rx_q];
      Alu_Ry  <= rf_q[ry_q];
      Alu_Sel <= op_q;
    end
  end

  // Capture the settled ALU result and flags at the end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      flg_q <= '0;
    end else if (state_q == EXEC) begin
      res_q <= Alu_R0;
      flg_q <= Alu_Flags;
    end
  end

  // Register file: external loads while idle, result writeback in WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (state_q == WB) begin
      rf_q[rd_q] <= res_q;
    end else if (ld_ok) begin
      rf_q[Ld_addr] <= Ld_data;
    end
  end

  // Architectural flags, updated with the writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                Flags_q <= '0;
    else if (state_q == WB) Flags_q <= flg_q;
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural model of the team ALU.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        Ins_valid;
  logic        Ins_ready;
  logic [11:0] Ins;
  logic        Ld_en;
  logic [2:0]  Ld_addr;
  logic [7:0]  Ld_data;
  logic [2:0]  Dbg_addr;
  logic [7:0]  Dbg_data;
  logic [7:0]  Alu_Rx, Alu_Ry, Alu_R0;
  logic [2:0]  Alu_Sel, Alu_Flags, Flags_q;
  logic        Busy, Done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NREG(8), .W(8)) dut (
    .clk(clk), .rst(rst),
    .Ins_valid(Ins_valid), .Ins_ready(Ins_ready), .Ins(Ins),
    .Ld_en(Ld_en), .Ld_addr(Ld_addr), .Ld_data(Ld_data),
    .Dbg_addr(Dbg_addr), .Dbg_data(Dbg_data),
    .Alu_Rx(Alu_Rx), .Alu_Ry(Alu_Ry), .Alu_Sel(Alu_Sel),
    .Alu_R0(Alu_R0), .Alu_Flags(Alu_Flags),
    .Flags_q(Flags_q), .Busy(Busy), .Done(Done)
  );

  // Team ALU: 0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 NOT, 5 AND, 6 OR, 7 XOR
  always_comb begin
    logic [8:0] t;
    logic       c;
    t = '0;
    c = 1'b0;
    case (Alu_Sel)
      3'd0: begin t = {1'b0, Alu_Rx} + {1'b0, Alu_Ry}; c = t[8]; end
      3'd1: begin t = {1'b0, Alu_Rx - Alu_Ry}; c = (Alu_Rx < Alu_Ry); end
      3'd2: begin t = {1'b0, Alu_Rx << 1}; c = Alu_Rx[7]; end
      3'd3: begin t = {1'b0, Alu_Rx >> 1}; c = Alu_Rx[0]; end
      3'd4: t = {1'b0, ~Alu_Rx};
      3'd5: t = {1'b0, Alu_Rx & Alu_Ry};
      3'd6: t = {1'b0, Alu_Rx | Alu_Ry};
      default: t = {1'b0, Alu_Rx ^ Alu_Ry};
    endcase
    Alu_R0    = t[7:0];
    Alu_Flags = {t[7], c, (t[7:0] == 8'h00)};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
    Dbg_addr = a;
    #1;
    d = Dbg_data;
  endtask

  // Called at a negedge while idle; returns at the next negedge
  task automatic load(input logic [2:0] a, input logic [7:0] d);
    Ld_en = 1'b1; Ld_addr = a; Ld_data = d;
    @(negedge clk);
    Ld_en = 1'b0;
  endtask

  // Called at a negedge while idle; returns at the first idle negedge after WB
  task automatic issue(input logic [2:0] op, rd, rx, ry);
    int n;
    int rdy_hi;
    chk("ready_before_issue", Ins_ready, 1);
    Ins = {op, rd, rx, ry};
    Ins_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Ins_valid = 1'b0;
    Ins = 12'hFFF;
    n = 1;
    rdy_hi = 0;
    while (!Done && n < 8) begin
      if (Ins_ready) rdy_hi++;
      @(negedge clk);
      n++;
    end
    chk("done_latency", n, 3);
    chk("ready_low_while_busy", rdy_hi, 0);
    @(negedge clk);
    chk("done_single_cycle", Done, 0);
  endtask

  typedef struct {
    logic [2:0] op, rd, rx, ry;
    logic [7:0] xv, yv;
    logic [7:0] er;
    logic [2:0] ef;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0]  d;
    logic [11:0] prog[3];
    int acc[3];
    int k, low, dones;

    tbl[0] = '{3'd0, 3'd3, 3'd1, 3'd2, 8'hF0, 8'h20, 8'h10, 3'b010};
    tbl[1] = '{3'd1, 3'd6, 3'd4, 3'd5, 8'h03, 8'h05, 8'hFE, 3'b110};
    tbl[2] = '{3'd1, 3'd7, 3'd5, 3'd5, 8'h05, 8'h05, 8'h00, 3'b001};
    tbl[3] = '{3'd5, 3'd3, 3'd1, 3'd2, 8'hF0, 8'h0F, 8'h00, 3'b001};
    tbl[4] = '{3'd4, 3'd2, 3'd6, 3'd0, 8'h5A, 8'h00, 8'hA5, 3'b100};
    tbl[5] = '{3'd7, 3'd0, 3'd3, 3'd4, 8'hFF, 8'h01, 8'hFE, 3'b100};
    tbl[6] = '{3'd1, 3'd1, 3'd2, 3'd3, 8'h80, 8'h01, 8'h7F, 3'b000};
    tbl[7] = '{3'd0, 3'd5, 3'd6, 3'd7, 8'hFF, 8'h01, 8'h00, 3'b011};

    rst = 1'b1; Ins_valid = 1'b0; Ins = '0;
    Ld_en = 1'b0; Ld_addr = '0; Ld_data = '0; Dbg_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_ready", Ins_ready, 1);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_flags", Flags_q, 0);
    chk("rst_alu_ops", {Alu_Rx, Alu_Ry, 5'd0, Alu_Sel}, 0);
    for (int i = 0; i < 8; i++) begin
      read_reg(i[2:0], d);
      chk("rst_reg", d, 0);
    end
    @(negedge clk);

    // Table-driven single instructions
    for (int v = 0; v < 8; v++) begin
      load(tbl[v].rx, tbl[v].xv);
      load(tbl[v].ry, tbl[v].yv);
      issue(tbl[v].op, tbl[v].rd, tbl[v].rx, tbl[v].ry);
      read_reg(tbl[v].rd, d);
      chk("vec_result", d, tbl[v].er);
      chk("vec_flags", Flags_q, tbl[v].ef);
      chk("vec_hold_rx", Alu_Rx, tbl[v].xv);
      chk("vec_hold_ry", Alu_Ry, tbl[v].yv);
      chk("vec_hold_sel", Alu_Sel, tbl[v].op);
      @(negedge clk);
    end

    // Back-to-back with Ins_valid held high
    load(3'd1, 8'hF0);
    load(3'd2, 8'h20);
    prog[0] = {3'd5, 3'd3, 3'd1, 3'd2};
    prog[1] = {3'd6, 3'd4, 3'd1, 3'd2};
    prog[2] = {3'd7, 3'd5, 3'd1, 3'd2};
    k = 0; low = 0; dones = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    for (int c = 0; c < 16; c++) begin
      if (k < 3) begin Ins = prog[k]; Ins_valid = 1'b1; end
      else Ins_valid = 1'b0;
      if (c < 12 && !Ins_ready) low++;
      if (Done) dones++;
      if (Ins_valid && Ins_ready) begin acc[k] = c; k++; end
      @(negedge clk);
    end
    chk("b2b_accepts", k, 3);
    chk("b2b_gap01", acc[1] - acc[0], 4);
    chk("b2b_gap12", acc[2] - acc[1], 4);
    chk("b2b_ready_low", low, 9);
    chk("b2b_dones", dones, 3);
    read_reg(3'd3, d); chk("b2b_and", d, 8'h20);
    read_reg(3'd4, d); chk("b2b_or", d, 8'hF0);
    read_reg(3'd5, d); chk("b2b_xor", d, 8'hD0);
    @(negedge clk);

    // Load in the accept cycle, load attempt during EXEC
    Ld_en = 1'b1; Ld_addr = 3'd1; Ld_data = 8'h7F;
    Ins = {3'd4, 3'd0, 3'd1, 3'd0}; Ins_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Ld_en = 1'b0; Ins_valid = 1'b0;
    @(negedge clk);
    Ld_en = 1'b1; Ld_addr = 3'd2; Ld_data = 8'hAA;
    @(negedge clk);
    Ld_en = 1'b0;
    chk("haz_done", Done, 1);
    @(negedge clk);
    read_reg(3'd0, d); chk("haz_not_result", d, 8'h80);
    read_reg(3'd1, d); chk("haz_loaded", d, 8'h7F);
    read_reg(3'd2, d); chk("haz_load_blocked", d, 8'h20);
    @(negedge clk);

    // Self-overwrite
    load(3'd1, 8'h40);
    issue(3'd0, 3'd1, 3'd1, 3'd1);
    read_reg(3'd1, d);
    chk("self_result", d, 8'h80);
    chk("self_flags", Flags_q, 3'b100);
    @(negedge clk);

    // Reset during EXEC
    load(3'd1, 8'h40);
    Ins = {3'd0, 3'd1, 3'd1, 3'd1}; Ins_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Ins_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", Busy, 0);
    chk("midrst_done", Done, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", Ins_ready, 1);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (Done) dones++;
    end
    chk("midrst_no_done", dones, 0);
    chk("midrst_flags", Flags_q, 0);
    chk("midrst_alu_ops", {Alu_Rx, Alu_Ry, 5'd0, Alu_Sel}, 0);
    for (int i = 0; i < 8; i++) begin
      read_reg(i[2:0], d);
      chk("midrst_reg", d, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer that owns an 8 x 8-bit register file and the 8-bit ALU's operand/opcode inputs.
- Accepts one 12-bit instruction at a time over a valid/ready handshake, reads two source registers and drives the ALU.
- Writes the ALU result to the destination register and latches the 3-bit ALU flags.
- Sits between the instruction source (decoder or testbench) and the ALU instance, which is external and purely combinational.

Parameters:
- NREG, 8, number of registers; fixed at 8 because the index fields are 3 bits.
- W, 8, register and ALU data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- Ins_valid  in  1  instruction present
- Ins_ready  out  1  controller can accept an instruction
- Ins  in  12  instruction fields: [11:9] op, [8:6] rd, [5:3] rx, [2:0] ry
- Ld_en  in  1  external register-file write strobe
- Ld_addr  in  3  register-file write index
- Ld_data  in  8  register-file write data
- Dbg_addr  in  3  debug read index
- Dbg_data  out  8  combinational read of regfile[Dbg_addr]
- Alu_Rx  out  8  ALU operand x
- Alu_Ry  out  8  ALU operand y
- Alu_Sel  out  3  ALU opcode
- Alu_R0  in  8  ALU result
- Alu_Flags  in  3  ALU flags: [0] zero, [1] carry/borrow, [2] sign
- Flags_q  out  3  flags of the last completed instruction
- Busy  out  1  high in any state other than IDLE
- Done  out  1  one-cycle pulse on writeback

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - State = IDLE, all registers = 0x00.
  - Alu_Rx = Alu_Ry = 0x00, Alu_Sel = 0, Flags_q = 0, Done = 0, Busy = 0.
  - Ins_ready = 1 once rst is deasserted.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE:
  - Ins_ready = 1.
  - On Ins_valid & Ins_ready, latch op/rd/rx/ry and go to READ.
- READ:
  - Load the Alu_Rx/Alu_Ry registers from regfile[rx]/regfile[ry] and Alu_Sel from op; go to EXEC.
  - For op = 4 (NOT), Alu_Ry is still loaded; the ALU ignores it.
- EXEC:
  - ALU inputs are stable and the ALU settles this cycle.
  - Capture Alu_R0 into a result register and Alu_Flags into a flag register; go to WB.
- WB:
  - Write regfile[rd] with the result and update Flags_q.
  - Done = 1 for exactly this cycle; go to IDLE.
- Latency: handshake in cycle N, Done in cycle N+3, regfile[rd] updated at the edge ending cycle N+3. Next accept is possible in cycle N+4. Throughput is 1 instruction per 4 cycles.
- Operand hold: Alu_Rx/Alu_Ry/Alu_Sel hold their last values in IDLE (no glitch to 0).
- Load port:
  - Ld_en is honoured only while Ins_ready = 1.
  - If Ld_en and an instruction accept occur in the same cycle, the load is written at that edge and READ sees the new value. Example: Ld_addr = rx gives the loaded data as the operand.
  - Ld_en while Busy is ignored; the regfile is unchanged.
- Register hazards:
  - rd == rx or rd == ry is legal; sources are read in READ, before WB.
  - rd == Ld_addr cannot collide because loads are blocked while Busy.
- Ins is sampled only at the accept edge; changes while Busy have no effect.
- Ins_valid held high continuously yields back-to-back instructions every 4 cycles, with no drops or duplicates.
- Reset mid-operation: immediate return to IDLE, no writeback, Done = 0, all state cleared.
- Data width: 8-bit result only. Carry/borrow is carried solely through Alu_Flags[1]; the controller does no arithmetic.

Test Plan:
- Bench instantiates the team ALU on the Alu_* ports.
- Load r1 = 0xF0, r2 = 0x20; Ins op0 rd3 rx1 ry2 -> Done at accept+3, r3 = 0x10, Flags_q = 3'b010.
- Load r4 = 0x03, r5 = 0x05; op1 rd6 rx4 ry5 -> r6 = 0xFE, Flags_q = 3'b110. Then op1 rd7 rx5 ry5 -> r7 = 0x00, Flags_q = 3'b001.
- Ins_valid held high with 3 queued ops (op5 AND, op6 OR, op7 XOR of r1, r2) -> accepts exactly 4 cycles apart, results 0x20, 0xF0, 0xD0. Ins_ready is low for the 3 cycles after each accept.
- Same-cycle Ld_en (addr 1, data 0x7F) and accept of op4 rd0 rx1 -> r0 = 0x80. Ld_en pulsed during EXEC (addr 2, data 0xAA) -> r2 unchanged.
- Accept op0 rd1 rx1 ry1 with r1 = 0x40 -> r1 = 0x80 (self-overwrite).
- Same instruction again with rst asserted during EXEC -> Done never pulses, all regs 0x00, Ins_ready = 1 the cycle after rst falls.
